// File: rtl/mips_pkg.sv
// Shared constants and FSM encoding for the instruction loader.
package mips_pkg;

   localparam int NB_DATA = 8;
   localparam int NB_32   = 32;
   localparam int NB_ADDR = 8;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [7:0]  ACK_BYTE  = 8'hA5;
   localparam logic [7:0]  NAK_BYTE  = 8'h5A;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RECV    = 3'd1;
   localparam logic [2:0] ST_WRITE   = 3'd2;
   localparam logic [2:0] ST_SEND    = 3'd3;
   localparam logic [2:0] ST_WAIT_TX = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      RECV    = ST_RECV,
      WRITE   = ST_WRITE,
      SEND    = ST_SEND,
      WAIT_TX = ST_WAIT_TX
   } state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs UART bytes little-endian into a word. word_next is the word as it
// will look once the byte being offered now is stored, so the caller can
// capture a complete word in the same cycle the last byte arrives.
module byte_packer #(
   parameter int NB_DATA = 8,
   parameter int NB_32   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               load,
   input  logic [NB_DATA-1:0] data,
   output logic [NB_32-1:0]   word_next,
   output logic               word_ready
);

   localparam int N_SLOTS = NB_32 / NB_DATA;
   localparam int NB_CNT  = $clog2(N_SLOTS);

   logic [NB_CNT-1:0] byte_cnt;
   logic [NB_32-1:0]  word;

   // Merge the incoming byte into its slot.
   always_comb begin
      word_next = word;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (load && (byte_cnt == NB_CNT'(i))) begin
            word_next[i*NB_DATA +: NB_DATA] = data;
         end
      end
   end

   assign word_ready = load && (byte_cnt == NB_CNT'(N_SLOTS - 1));

   // Slot counter wraps naturally after the last slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         word     <= '0;
      end else if (clr) begin
         byte_cnt <= '0;
      end else if (load) begin
         byte_cnt <= byte_cnt + 1'b1;
         word     <= word_next;
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Loads a program from the UART into instruction memory, one word per four
// bytes, then reports ACK (HALT seen) or NAK (memory full) back to the host.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for i_start, received bytes ignored
// RECV    | collecting bytes of the current word
// WRITE   | o_we cycle, decide halt / overflow / continue
// SEND    | status byte selected, tx strobe next cycle
// WAIT_TX | waiting for uart_tx to finish the status byte
module instr_loader #(
   parameter int          NB_DATA   = mips_pkg::NB_DATA,
   parameter int          NB_32     = mips_pkg::NB_32,
   parameter int          NB_ADDR   = mips_pkg::NB_ADDR,
   parameter logic [31:0] HALT_WORD = mips_pkg::HALT_WORD,
   parameter logic [7:0]  ACK_BYTE  = mips_pkg::ACK_BYTE,
   parameter logic [7:0]  NAK_BYTE  = mips_pkg::NAK_BYTE
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic               i_tx_done,
   output logic [NB_32-1:0]   o_instruction,
   output logic [NB_ADDR-1:0] o_instr_addr,
   output logic               o_we,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error
);

   import mips_pkg::*;

   localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;

   state_t               state, state_next;
   logic [NB_ADDR-1:0]   addr, addr_d;
   logic [NB_32-1:0]     instr_d, word_next;
   logic [NB_ADDR-1:0]   iaddr_d;
   logic [NB_DATA-1:0]   tx_data_d;
   logic                 err_d, done_d, tx_start_d, we_d, busy_d;
   logic                 start_ok, pk_load, word_ready, is_halt, is_last;

   assign start_ok = (state == IDLE) && i_start;
   assign is_halt  = (o_instruction == NB_32'(HALT_WORD));
   assign is_last  = (addr == ADDR_LAST);
   // A byte landing in WRITE belongs to the next word only if loading goes on.
   assign pk_load  = i_rx_done &&
                     ((state == RECV) || ((state == WRITE) && !is_halt && !is_last));

   byte_packer #(
      .NB_DATA (NB_DATA),
      .NB_32   (NB_32)
   ) u_packer (
      .clk        (clk),
      .rst_n      (i_rst_n),
      .clr        (start_ok),
      .load       (pk_load),
      .data       (i_rx_data),
      .word_next  (word_next),
      .word_ready (word_ready)
   );

   // Next state and next values of every registered output.
   always_comb begin
      state_next = state;
      addr_d     = addr;
      instr_d    = o_instruction;
      iaddr_d    = o_instr_addr;
      tx_data_d  = o_tx_data;
      err_d      = o_error;
      done_d     = 1'b0;
      tx_start_d = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_next = RECV;
               addr_d     = '0;
               err_d      = 1'b0;
            end
         end
         RECV: begin
            if (word_ready) begin
               state_next = WRITE;
               instr_d    = word_next;
               iaddr_d    = addr;
            end
         end
         WRITE: begin
            if (is_halt) begin
               tx_data_d  = NB_DATA'(ACK_BYTE);
               state_next = SEND;
            end else if (is_last) begin
               err_d      = 1'b1;
               tx_data_d  = NB_DATA'(NAK_BYTE);
               state_next = SEND;
            end else begin
               addr_d     = addr + 1'b1;
               state_next = RECV;
            end
         end
         SEND: begin
            tx_start_d = 1'b1;
            state_next = WAIT_TX;
         end
         WAIT_TX: begin
            if (i_tx_done) begin
               state_next = IDLE;
               done_d     = (o_tx_data == NB_DATA'(ACK_BYTE));
            end
         end
         default: state_next = IDLE;
      endcase
      we_d   = (state_next == WRITE);
      busy_d = (state_next != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         addr          <= '0;
         o_instruction <= '0;
         o_instr_addr  <= '0;
         o_tx_data     <= '0;
         o_we          <= 1'b0;
         o_tx_start    <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_error       <= 1'b0;
      end else begin
         state         <= state_next;
         addr          <= addr_d;
         o_instruction <= instr_d;
         o_instr_addr  <= iaddr_d;
         o_tx_data     <= tx_data_d;
         o_we          <= we_d;
         o_tx_start    <= tx_start_d;
         o_busy        <= busy_d;
         o_done        <= done_d;
         o_error       <= err_d;
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench: a default-depth loader (dut) and a 4-word loader (dut2)
// share all inputs; expected values are hand computed.
module tb_instr_loader;

   logic       clk = 1'b0;
   logic       i_rst_n, i_start, i_rx_done, i_tx_done;
   logic [7:0] i_rx_data;

   logic [31:0] o_instruction, o2_instruction;
   logic [7:0]  o_instr_addr;
   logic [1:0]  o2_instr_addr;
   logic        o_we, o_tx_start, o_busy, o_done, o_error;
   logic        o2_we, o2_tx_start, o2_busy, o2_done, o2_error;
   logic [7:0]  o_tx_data, o2_tx_data;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instr_loader dut (
      .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
      .o_instruction(o_instruction), .o_instr_addr(o_instr_addr), .o_we(o_we),
      .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
      .o_done(o_done), .o_error(o_error)
   );

   instr_loader #(.NB_ADDR(2)) dut2 (
      .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
      .o_instruction(o2_instruction), .o_instr_addr(o2_instr_addr), .o_we(o2_we),
      .o_tx_start(o2_tx_start), .o_tx_data(o2_tx_data), .o_busy(o2_busy),
      .o_done(o2_done), .o_error(o2_error)
   );

   typedef struct {
      bit          start;
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] word;
      logic [7:0]  addr;
      bit          halt;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_done = 1'b1;
      @(negedge clk);
      i_rx_done = 1'b0;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Sends four bytes two cycles apart; returns in the cycle o_we should be high.
   task automatic send_word(input logic [7:0] b0, b1, b2, b3);
      drive_byte(b0); idle(1);
      drive_byte(b1); idle(1);
      drive_byte(b2); idle(1);
      drive_byte(b3);
   endtask

   task automatic check_write(input string name, input logic [31:0] w, input logic [7:0] a);
      chk({name, " we"},    o_we,          1);
      chk({name, " instr"}, o_instruction, w);
      chk({name, " addr"},  o_instr_addr,  a);
   endtask

   // Called in the HALT write cycle: ACK handshake and done pulse.
   task automatic finish_ack(input string name);
      @(negedge clk);
      chk({name, " tx_start early"}, o_tx_start, 0);
      @(negedge clk);
      chk({name, " tx_start"}, o_tx_start, 1);
      chk({name, " tx_data"},  o_tx_data,  8'hA5);
      chk({name, " busy tx"},  o_busy,     1);
      idle(2);
      i_tx_done = 1'b1;
      @(negedge clk);
      i_tx_done = 1'b0;
      chk({name, " done"},  o_done,  1);
      chk({name, " idle"},  o_busy,  0);
      chk({name, " error"}, o_error, 0);
      @(negedge clk);
      chk({name, " done pulse"}, o_done, 0);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      idle(2);
      chk("rst instr",    o_instruction, 0);
      chk("rst addr",     o_instr_addr,  0);
      chk("rst tx_data",  o_tx_data,     0);
      chk("rst we",       o_we,          0);
      chk("rst tx_start", o_tx_start,    0);
      chk("rst busy",     o_busy,        0);
      chk("rst done",     o_done,        0);
      chk("rst error",    o_error,       0);
      chk("rst2 busy",    o2_busy,       0);
      chk("rst2 error",   o2_error,      0);
      i_rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{1, 8'h20, 8'h08, 8'h00, 8'h01, 32'h0100_0820, 8'd0, 0};
      tbl[1] = '{0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 8'd1, 1};
      tbl[2] = '{1, 8'h78, 8'h56, 8'h34, 8'h12, 32'h1234_5678, 8'd0, 0};
      tbl[3] = '{0, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF, 8'd1, 0};
      tbl[4] = '{0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 8'd2, 1};

      i_rst_n = 1'b0; i_start = 1'b0; i_rx_done = 1'b0; i_tx_done = 1'b0; i_rx_data = 8'h00;
      idle(1);
      do_reset();

      // Programs from the table, each ending in HALT.
      for (int i = 0; i < 5; i++) begin
         idle(2);
         if (tbl[i].start) begin
            pulse_start();
            chk($sformatf("vec%0d busy", i), o_busy, 1);
         end
         send_word(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3);
         check_write($sformatf("vec%0d", i), tbl[i].word, tbl[i].addr);
         if (tbl[i].halt) finish_ack($sformatf("vec%0d", i));
      end

      // Bytes without i_start are ignored.
      idle(2);
      for (int i = 0; i < 4; i++) begin
         drive_byte(8'h30 + 8'(i));
         chk($sformatf("nostart we%0d", i), o_we, 0);
         chk($sformatf("nostart busy%0d", i), o_busy, 0);
         idle(1);
      end

      // Overflow on the 4-word loader; the deep loader keeps receiving.
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         send_word(8'h10 + 8'(4*k), 8'h11 + 8'(4*k), 8'h12 + 8'(4*k), 8'h13 + 8'(4*k));
         chk($sformatf("ovf we%0d", k), o2_we, 1);
         chk($sformatf("ovf instr%0d", k), o2_instruction,
             {8'h13 + 8'(4*k), 8'h12 + 8'(4*k), 8'h11 + 8'(4*k), 8'h10 + 8'(4*k)});
         chk($sformatf("ovf addr%0d", k), o2_instr_addr, k);
         if (k < 3) idle(2);
      end
      @(negedge clk);
      chk("ovf error set", o2_error, 1);
      chk("ovf tx_start early", o2_tx_start, 0);
      @(negedge clk);
      chk("ovf tx_start", o2_tx_start, 1);
      chk("ovf tx_data",  o2_tx_data,  8'h5A);
      idle(2);
      i_tx_done = 1'b1;
      @(negedge clk);
      i_tx_done = 1'b0;
      chk("ovf no done",    o2_done,  0);
      chk("ovf idle",       o2_busy,  0);
      chk("ovf error held", o2_error, 1);
      idle(1);
      chk("ovf no done later", o2_done, 0);
      pulse_start();
      chk("ovf error cleared", o2_error, 0);
      chk("ovf restart busy",  o2_busy,  1);
      // i_start above hit the deep loader mid-load and must not restart it.
      idle(1);
      send_word(8'h01, 8'h02, 8'h03, 8'h04);
      check_write("busy start ignored", 32'h0403_0201, 8'd4);

      // Reset in the middle of a word discards the partial bytes.
      idle(2);
      do_reset();
      pulse_start();
      drive_byte(8'h11); idle(1);
      drive_byte(8'h22); idle(1);
      do_reset();
      pulse_start();
      send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      check_write("after reset", 32'hDDCC_BBAA, 8'd0);

      // Byte arriving in the WRITE cycle starts the next word; starts in RECV ignored.
      idle(2);
      do_reset();
      pulse_start();
      drive_byte(8'h01);
      pulse_start();
      drive_byte(8'h02); idle(1);
      drive_byte(8'h03); idle(1);
      drive_byte(8'h04);
      check_write("wr0", 32'h0403_0201, 8'd0);
      drive_byte(8'h05);
      idle(1);
      drive_byte(8'h06); idle(1);
      drive_byte(8'h07);
      pulse_start();
      drive_byte(8'h08);
      check_write("wr1 write-cycle byte", 32'h0807_0605, 8'd1);
      idle(1);
      send_word(8'h09, 8'h0A, 8'h0B, 8'h0C);
      check_write("wr2 spacing2", 32'h0C0B_0A09, 8'd2);
      idle(2);
      send_word(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      check_write("wr3 halt", 32'hFFFF_FFFF, 8'd3);
      finish_ack("wr3");

      idle(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
